// File: rtl/mem_rw_initiator.sv
// mem_rw_initiator: host valid/ready front end for the 8-bit parity memory port.
// Sequences single write strobes and RD_LATENCY-cycle read strobes. It returns
// read data with a parity-error flag. A response is held until the host accepts it.
// Optional build macro MEM_RW_INITIATOR_PERR_COUNT_EN compiles in the saturating
// parity-error counter. When the macro is undefined, err_count is tied to 0 and
// err_clr is ignored.
// RD_LATENCY legal range is 1..4.

module mem_rw_initiator #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [15:0]      req_addr,
    input  logic [7:0]       req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_rdata,
    output logic             rsp_perr,
    output logic             mem_write,
    output logic             mem_read,
    output logic [15:0]      mem_address,
    output logic [7:0]       mem_data_in,
    input  logic [8:0]       mem_data_out,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned LAT_W  = 2;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t              state_q,       state_d;
    logic [LAT_W-1:0]    lat_cnt_q,     lat_cnt_d;
    logic                req_ready_q,   req_ready_d;
    logic                mem_write_q,   mem_write_d;
    logic                mem_read_q,    mem_read_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                rsp_perr_q,    rsp_perr_d;

    logic                capture_c;
    logic                perr_c;

    // Last READ_WAIT cycle: memory data is valid on the closing edge.
    assign capture_c = (state_q == READ_WAIT) && (lat_cnt_q == LAT_W'(RD_LATENCY - 1));
    // Stored parity bit against recomputed parity of the data byte.
    assign perr_c    = mem_data_out[8] ^ (^mem_data_out[7:0]);

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        req_ready_d   = req_ready_q;
        mem_write_d   = mem_write_q;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_perr_d    = rsp_perr_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d   = 1'b0;
                    mem_address_d = req_addr;
                    lat_cnt_d     = '0;
                    if (req_write) begin
                        state_d       = WRITE;
                        mem_write_d   = 1'b1;
                        mem_data_in_d = req_wdata;
                    end else begin
                        state_d    = READ_WAIT;
                        mem_read_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_d     = IDLE;
                mem_write_d = 1'b0;
                req_ready_d = 1'b1;
            end
            READ_WAIT: begin
                if (capture_c) begin
                    state_d     = RESP;
                    lat_cnt_d   = '0;
                    mem_read_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = mem_data_out[7:0];
                    rsp_perr_d  = perr_c;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_write_d = 1'b0;
                mem_read_d  = 1'b0;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            lat_cnt_q     <= '0;
            req_ready_q   <= 1'b1;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_perr_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            req_ready_q   <= req_ready_d;
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_perr_q    <= rsp_perr_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign mem_write   = mem_write_q;
    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_perr    = rsp_perr_q;

`ifdef MEM_RW_INITIATOR_PERR_COUNT_EN
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Saturating error count; clear wins over a same-cycle increment.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (capture_c && perr_c && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    // Error count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    logic err_clr_unused;

    assign err_clr_unused = err_clr;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_mem_rw_initiator.sv
// Randomized self-checking bench for mem_rw_initiator.
// Two instances are tested: RD_LATENCY=1/CNT_W=16 and RD_LATENCY=3/CNT_W=2.
// The memory model returns valid data only in the final read-wait cycle.
module tb_mem_rw_initiator;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk = 1'b0;
    logic        rst          [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_write    [2];
    logic [15:0] req_addr     [2];
    logic [7:0]  req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [7:0]  rsp_rdata    [2];
    logic        rsp_perr     [2];
    logic        mem_write    [2];
    logic        mem_read     [2];
    logic [15:0] mem_address  [2];
    logic [7:0]  mem_data_in  [2];
    logic [8:0]  mem_data_out [2];
    logic        err_clr      [2];
    logic [15:0] err_count0;
    logic [1:0]  err_count1;

    logic [8:0]  mem_arr [2][65536];
    int          rd_cyc  [2];
    int          cnt_model [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mem_rw_initiator #(.RD_LATENCY(LAT0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_perr(rsp_perr[0]),
        .mem_write(mem_write[0]), .mem_read(mem_read[0]), .mem_address(mem_address[0]),
        .mem_data_in(mem_data_in[0]), .mem_data_out(mem_data_out[0]),
        .err_clr(err_clr[0]), .err_count(err_count0)
    );

    mem_rw_initiator #(.RD_LATENCY(LAT1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_perr(rsp_perr[1]),
        .mem_write(mem_write[1]), .mem_read(mem_read[1]), .mem_address(mem_address[1]),
        .mem_data_in(mem_data_in[1]), .mem_data_out(mem_data_out[1]),
        .err_clr(err_clr[1]), .err_count(err_count1)
    );

    // Memory: correct word only in the last strobe cycle, inverted garbage otherwise.
    assign mem_data_out[0] = (mem_read[0] && rd_cyc[0] == LAT0 - 1) ?
                             mem_arr[0][mem_address[0]] : ~mem_arr[0][mem_address[0]];
    assign mem_data_out[1] = (mem_read[1] && rd_cyc[1] == LAT1 - 1) ?
                             mem_arr[1][mem_address[1]] : ~mem_arr[1][mem_address[1]];

    // Number of completed cycles the current read strobe has been high.
    always_ff @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d] || !mem_read[d]) rd_cyc[d] <= 0;
            else                        rd_cyc[d] <= rd_cyc[d] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_cnt(input int d);
        return (d == 0) ? 32'(err_count0) : 32'(err_count1);
    endfunction

    function automatic int cnt_max(input int d);
        return (d == 0) ? 65535 : 3;
    endfunction

    function automatic logic [31:0] exp_cnt(input int d);
`ifdef MEM_RW_INITIATOR_PERR_COUNT_EN
        return 32'(cnt_model[d]);
`else
        return 32'(0);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            check("strobe_excl", 32'(mem_write[d] & mem_read[d]), 32'(0));
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_req_ready"}, 32'(req_ready[d]), 32'(1));
        check({tag, "_mem_write"}, 32'(mem_write[d]), 32'(0));
        check({tag, "_mem_read"},  32'(mem_read[d]),  32'(0));
        check({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'(0));
        check({tag, "_err_count"}, obs_cnt(d), exp_cnt(d));
    endtask

    task automatic do_write(input int d, input logic [15:0] addr, input logic [7:0] data);
        req_valid[d] = 1'b1;
        req_write[d] = 1'b1;
        req_addr[d]  = addr;
        req_wdata[d] = data;
        step();
        req_valid[d] = 1'b0;
        req_addr[d]  = 16'($urandom);
        check("wr_mem_write", 32'(mem_write[d]),   32'(1));
        check("wr_mem_read",  32'(mem_read[d]),    32'(0));
        check("wr_addr",      32'(mem_address[d]), 32'(addr));
        check("wr_data",      32'(mem_data_in[d]), 32'(data));
        check("wr_req_ready", 32'(req_ready[d]),   32'(0));
        mem_arr[d][addr] = {^data, data};
        step();
        check_idle(d, "wr_done");
    endtask

    task automatic do_read(input int d, input logic [15:0] addr, input int hold, input bit clr_at_cap);
        int         lat;
        logic [8:0] word;
        logic       exp_perr;
        lat      = (d == 0) ? LAT0 : LAT1;
        word     = mem_arr[d][addr];
        exp_perr = word[8] ^ (^word[7:0]);
        req_valid[d] = 1'b1;
        req_write[d] = 1'b0;
        req_addr[d]  = addr;
        req_wdata[d] = 8'($urandom);
        step();
        req_valid[d] = 1'b0;
        for (int i = 0; i < lat; i++) begin
            check("rd_mem_read",  32'(mem_read[d]),    32'(1));
            check("rd_mem_write", 32'(mem_write[d]),   32'(0));
            check("rd_addr",      32'(mem_address[d]), 32'(addr));
            check("rd_early_rsp", 32'(rsp_valid[d]),   32'(0));
            check("rd_req_ready", 32'(req_ready[d]),   32'(0));
            if (clr_at_cap && i == lat - 1) err_clr[d] = 1'b1;
            step();
            err_clr[d] = 1'b0;
        end
        if (clr_at_cap)                                   cnt_model[d] = 0;
        else if (exp_perr && cnt_model[d] < cnt_max(d))   cnt_model[d]++;
        check("rsp_valid",     32'(rsp_valid[d]), 32'(1));
        check("rsp_rdata",     32'(rsp_rdata[d]), 32'(word[7:0]));
        check("rsp_perr",      32'(rsp_perr[d]),  32'(exp_perr));
        check("rsp_mem_read",  32'(mem_read[d]),  32'(0));
        check("rsp_req_ready", 32'(req_ready[d]), 32'(0));
        check("rsp_err_count", obs_cnt(d),        exp_cnt(d));
        for (int h = 0; h < hold; h++) begin
            req_valid[d] = 1'b1;
            step();
            check("bp_rsp_valid", 32'(rsp_valid[d]), 32'(1));
            check("bp_rdata",     32'(rsp_rdata[d]), 32'(word[7:0]));
            check("bp_perr",      32'(rsp_perr[d]),  32'(exp_perr));
            check("bp_mem_read",  32'(mem_read[d]),  32'(0));
            check("bp_mem_write", 32'(mem_write[d]), 32'(0));
            check("bp_req_ready", 32'(req_ready[d]), 32'(0));
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        step();
        rsp_ready[d] = 1'b0;
        check_idle(d, "rd_done");
    endtask

    task automatic do_clr(input int d);
        err_clr[d] = 1'b1;
        step();
        err_clr[d] = 1'b0;
        cnt_model[d] = 0;
        check("clr_err_count", obs_cnt(d), exp_cnt(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v;
        logic [15:0] a;
        int          d;
        int          op;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
            err_clr[k] = 1'b0; cnt_model[k] = 0;
            for (int m = 0; m < 65536; m++) begin
                v = 8'(m) ^ 8'(m >> 8);
                mem_arr[k][m] = {^v, v};
            end
        end

        step();
        step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_idle(k, "reset");
            check("reset_addr",  32'(mem_address[k]), 32'(0));
            check("reset_wdata", 32'(mem_data_in[k]), 32'(0));
            check("reset_rdata", 32'(rsp_rdata[k]),   32'(0));
            check("reset_perr",  32'(rsp_perr[k]),    32'(0));
        end

        // Directed: write, good read, bad read, clear, backpressure.
        do_write(0, 16'h1234, 8'hA5);
        check("mem_word_1234", 32'(mem_arr[0][16'h1234]), 32'(9'h0A5));
        do_read(0, 16'h1234, 0, 1'b0);
        mem_arr[0][16'h1234] = 9'h007;
        do_read(0, 16'h1234, 0, 1'b0);
        do_clr(0);
        do_read(0, 16'h1234, 3, 1'b0);
        do_read(0, 16'h1234, 0, 1'b1);

        // Directed: latency 3 with a 2-bit counter saturating.
        mem_arr[1][16'h0010] = 9'h007;
        for (int r = 0; r < 5; r++) do_read(1, 16'h0010, 0, 1'b0);
        do_write(1, 16'h0020, 8'h3C);
        do_read(1, 16'h0020, 1, 1'b0);

        // Reset asserted in the second read-wait cycle discards the read.
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 16'h0010;
        step();
        req_valid[1] = 1'b0;
        step();
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        cnt_model[1] = 0;
        check("rstmid_mem_read",  32'(mem_read[1]),  32'(0));
        check("rstmid_rsp_valid", 32'(rsp_valid[1]), 32'(0));
        check("rstmid_req_ready", 32'(req_ready[1]), 32'(1));
        check("rstmid_err_count", obs_cnt(1),        32'(0));
        rsp_ready[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check("rstmid_no_rsp",  32'(rsp_valid[1]), 32'(0));
            check("rstmid_no_read", 32'(mem_read[1]),  32'(0));
        end
        rsp_ready[1] = 1'b0;

        // Randomized mix of writes, reads, corrupted reads and clears.
        for (int it = 0; it < 80; it++) begin
            d  = int'($urandom_range(0, 1));
            a  = 16'h4000 + 16'($urandom_range(0, 7));
            op = int'($urandom_range(0, 9));
            if (op < 3) begin
                do_write(d, a, 8'($urandom));
            end else if (op < 6) begin
                do_read(d, a, int'($urandom_range(0, 3)), 1'b0);
            end else if (op < 9) begin
                mem_arr[d][a][8] = ~mem_arr[d][a][8];
                do_read(d, a, int'($urandom_range(0, 2)), 1'b0);
            end else begin
                do_clr(d);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_rw_initiator.md
Name: mem_rw_initiator

Overview:
- Synthesizable initiator for the 8-bit-data / 16-bit-address / 9-bit-parity-read memory port used by our parity memory (write, read, address, data_in, data_out = {^data, data}).
- Accepts single read/write requests from a host over valid/ready, sequences the memory strobes, and returns read data with a parity-error flag.
- Keeps a saturating parity-error count.
- Sits between host logic and the memory, replacing bench-driven strobes in integrated builds.

Parameters:
- RD_LATENCY, 1, cycles from the first mem_read-high edge to valid mem_data_out; legal range 1..4.
- CNT_W, 16, width of err_count.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  host request valid
- req_ready  out  1  initiator can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  16  request address
- req_wdata  in  8  write data
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  8  read data (mem_data_out[7:0])
- rsp_perr  out  1  parity mismatch on this read
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_address  out  16  memory address
- mem_data_in  out  8  memory write data
- mem_data_out  in  9  memory read data {parity, data}
- err_clr  in  1  synchronous clear of err_count
- err_count  out  CNT_W  saturating parity-error count

Behaviour:
- One clock, clk. Reset is rst: synchronous, active-high.
- Reset values:
  - All outputs are 0 except req_ready = 1.
  - FSM is in IDLE.
  - Latency counter is 0.
- FSM states: IDLE, WRITE, READ_WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, the request is registered.
  - Next state is WRITE if req_write = 1, otherwise READ_WAIT.
- WRITE (exactly 1 cycle):
  - mem_write = 1, mem_address = captured addr, mem_data_in = captured wdata.
  - req_ready = 0.
  - Next state is IDLE.
  - Write throughput is one per 2 cycles.
- READ_WAIT (RD_LATENCY cycles):
  - mem_read = 1 and mem_address is held stable for the whole state.
  - A counter runs from 0 to RD_LATENCY-1.
  - On the edge ending the last cycle, mem_data_out is captured:
    - rsp_rdata = mem_data_out[7:0]
    - rsp_perr = mem_data_out[8] XOR (^mem_data_out[7:0])
  - Next state is RESP.
- RESP:
  - rsp_valid = 1; mem_read = 0; req_ready = 0.
  - rsp_rdata and rsp_perr stay stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid drops next cycle and the FSM returns to IDLE.
  - Minimum read turnaround: accept edge → RD_LATENCY cycles → RESP.
- mem_write and mem_read are never high in the same cycle. Both are 0 in IDLE and RESP.
- Host request fields are don't-care when req_valid = 0. The host must hold them stable while req_valid & !req_ready.
- err_count:
  - Increments by 1 on each capture with perr = 1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - err_clr has priority over a simultaneous increment; the result is 0.
- Reset mid-operation:
  - Any in-flight write strobe or read is abandoned; the pending response is discarded.
  - err_count clears.
  - Outputs take reset values on the next edge.

Optional Feature:
- Macro: MEM_RW_INITIATOR_PERR_COUNT_EN.
- Defined: err_count and err_clr behave as above.
- Undefined: the counter logic is not compiled, err_count is tied to 0, and err_clr is ignored. rsp_perr still functions.

Test Plan:
- Write: host sends write 0x1234 / 0xA5 → next cycle mem_write = 1 for exactly one cycle, mem_address = 0x1234, mem_data_in = 0xA5, mem_read = 0; req_ready = 1 again the cycle after.
- Read, good parity (RD_LATENCY = 1): model returns 9'h0A5 for 0x1234 → mem_read high 1 cycle, then rsp_valid = 1 with rsp_rdata = 0xA5, rsp_perr = 0; err_count stays 0.
- Read, bad parity: model returns 9'h007 (0x07 has odd parity, so the correct word is 9'h107) → rsp_rdata = 0x07, rsp_perr = 1, err_count = 1. Then err_clr pulse → err_count = 0.
- Backpressure: hold rsp_ready = 0 for 3 cycles during RESP → rsp_valid, rsp_rdata and rsp_perr stay constant, req_ready = 0, and no mem strobes occur. Raise rsp_ready → IDLE next cycle.
- Latency and saturation: RD_LATENCY = 3, CNT_W = 2, five bad-parity reads → mem_read high 3 cycles per read, capture on the third, err_count = 3 (saturated).
- Reset mid-read: assert rst during the second READ_WAIT cycle → next edge has mem_read = 0, rsp_valid = 0, req_ready = 1, err_count = 0, and no response is ever issued for that request.
